decode_stage_sb: RTL

- Parametrised successor to the single-cycle decode block.
- Holds the register file with writeback bypass and a per-register pending-write scoreboard that stalls on RAW hazards.
- Performs immediate extension to DATA_W and drives a valid/ready ID/EX pipeline register.
- Sits between fetch (IF/ID) and execute; opcode control decoding stays in the external master control, whose outputs feed the ctl_* ports.

---
 rtl/decode_stage_sb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/decode_stage_sb.sv
// Decode stage: register file with writeback bypass, pending-write
// scoreboard, immediate extension and a valid/ready ID/EX register.
// Optional macro DEC_STALL_CNT_EN enables the stall_cycles counter.
module decode_stage_sb #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [15:0]       if_instr,
    output logic              id_ready,
    input  logic              ctl_uses_rs,
    input  logic              ctl_uses_rt,
    input  logic              ctl_reg_write,
    input  logic [REG_AW-1:0] ctl_dst,
    input  logic [2:0]        ctl_imm_sel,
    input  logic              flush,
    input  logic              wb_write,
    input  logic [REG_AW-1:0] wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [15:0]       ex_instr,
    output logic [REG_AW-1:0] ex_dst,
    output logic              ex_reg_write,
    output logic              err,
    output logic [31:0]       stall_cycles
);

    localparam int NUM_REGS = 2 ** REG_AW;
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic [DATA_W-1:0] regs     [NUM_REGS];
    logic [CNT_W-1:0]  pend     [NUM_REGS];
    logic [CNT_W-1:0]  pend_nxt [NUM_REGS];

    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm;
    logic              imm_ok;
    logic              haz_rs;
    logic              haz_rt;
    logic              haz_sat;
    logic              hazard;
    logic              fire;
    logic              wb_orphan;
    logic [NUM_REGS-1:0] inc_v;
    logic [NUM_REGS-1:0] dwb_v;
    logic [NUM_REGS-1:0] dfl_v;
    logic [CNT_W+1:0]  up;
    logic [CNT_W+1:0]  dn;

    assign rs = REG_AW'(if_instr[10:8]);
    assign rt = REG_AW'(if_instr[7:5]);

    assign op_a = (wb_write && wb_sel == rs) ? wb_data : regs[rs];
    assign op_b = (wb_write && wb_sel == rt) ? wb_data : regs[rt];

    // A single outstanding write retiring this cycle is covered by bypass.
    assign haz_rs = ctl_uses_rs && pend[rs] != '0 &&
                    !(pend[rs] == CNT_W'(1) && wb_write && wb_sel == rs);
    assign haz_rt = ctl_uses_rt && pend[rt] != '0 &&
                    !(pend[rt] == CNT_W'(1) && wb_write && wb_sel == rt);
    assign haz_sat = ctl_reg_write && pend[ctl_dst] == PEND_MAX;
    assign hazard  = haz_rs || haz_rt || haz_sat;

    assign id_ready  = !hazard && !flush && (!ex_valid || ex_ready);
    assign fire      = if_valid && id_ready;
    assign wb_orphan = wb_write && pend[wb_sel] == '0;

    assign inc_v = (fire && ctl_reg_write) ?
                   (NUM_REGS'(1) << ctl_dst) : '0;
    assign dwb_v = wb_write ? (NUM_REGS'(1) << wb_sel) : '0;
    assign dfl_v = (flush && ex_valid && ex_reg_write) ?
                   (NUM_REGS'(1) << ex_dst) : '0;

    // Immediate extension; unsupported selectors yield zero and flag err.
    always_comb begin
        imm    = '0;
        imm_ok = 1'b1;
        case (ctl_imm_sel)
            3'd0: imm = {{(DATA_W-5){if_instr[4]}}, if_instr[4:0]};
            3'd1: imm = {{(DATA_W-5){1'b0}}, if_instr[4:0]};
            3'd2: imm = {{(DATA_W-8){if_instr[7]}}, if_instr[7:0]};
            3'd3: imm = {{(DATA_W-8){1'b0}}, if_instr[7:0]};
            3'd4: imm = {{(DATA_W-11){if_instr[10]}}, if_instr[10:0]};
            default: imm_ok = 1'b0;
        endcase
    end

    // Scoreboard next state: issue adds, writeback and flush-kill subtract.
    always_comb begin
        up = '0;
        dn = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            up = {2'b00, pend[i]} + (CNT_W+2)'(inc_v[i]);
            dn = (CNT_W+2)'(dwb_v[i]) + (CNT_W+2)'(dfl_v[i]);
            pend_nxt[i] = (up > dn) ? CNT_W'(up - dn) : '0;
        end
    end

    // Pending-write counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) pend[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) pend[i] <= pend_nxt[i];
        end
    end

    // Register file writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_write) begin
            regs[wb_sel] <= wb_data;
        end
    end

    // ID/EX pipeline register with hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_a         <= '0;
            ex_b         <= '0;
            ex_imm       <= '0;
            ex_instr     <= '0;
            ex_dst       <= '0;
            ex_reg_write <= 1'b0;
        end else if (fire) begin
            ex_valid     <= 1'b1;
            ex_a         <= op_a;
            ex_b         <= op_b;
            ex_imm       <= imm;
            ex_instr     <= if_instr;
            ex_dst       <= ctl_dst;
            ex_reg_write <= ctl_reg_write;
        end else if (flush || ex_ready) begin
            ex_valid     <= 1'b0;
        end
    end

    // Registered one-cycle error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= wb_orphan || (fire && !imm_ok);
        end
    end

`ifdef DEC_STALL_CNT_EN
    // Count cycles where a valid instruction is held back by decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (if_valid && !id_ready && !flush) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule
